// File: rtl/ace_snoop_collector.sv
// Snoop fan-out/fan-in for one master group: broadcasts an AC request to masked masters,
// merges their CR responses, forwards CD data from one selected master and drains the rest.
module ace_snoop_collector #(
   parameter  int unsigned NoMst     = 4,
   parameter  int unsigned AddrWidth = 64,
   parameter  int unsigned DataWidth = 64,
   parameter  int unsigned CdBeats   = 4,
   localparam int unsigned SrcW      = (NoMst > 1) ? $clog2(NoMst) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       ac_valid_i,
   output logic                       ac_ready_o,
   input  logic [AddrWidth-1:0]       ac_addr_i,
   input  logic [3:0]                 ac_snoop_i,
   input  logic [2:0]                 ac_prot_i,
   input  logic [NoMst-1:0]           mask_i,
   output logic [NoMst-1:0]           snp_ac_valid_o,
   input  logic [NoMst-1:0]           snp_ac_ready_i,
   output logic [AddrWidth-1:0]       snp_ac_addr_o,
   output logic [3:0]                 snp_ac_snoop_o,
   output logic [2:0]                 snp_ac_prot_o,
   input  logic [NoMst-1:0]           snp_cr_valid_i,
   output logic [NoMst-1:0]           snp_cr_ready_o,
   input  logic [5*NoMst-1:0]         snp_cr_resp_i,
   input  logic [NoMst-1:0]           snp_cd_valid_i,
   output logic [NoMst-1:0]           snp_cd_ready_o,
   input  logic [DataWidth*NoMst-1:0] snp_cd_data_i,
   input  logic [NoMst-1:0]           snp_cd_last_i,
   output logic                       cr_valid_o,
   input  logic                       cr_ready_i,
   output logic [4:0]                 cr_resp_o,
   output logic [SrcW-1:0]            cr_src_o,
   output logic                       cd_valid_o,
   input  logic                       cd_ready_i,
   output logic [DataWidth-1:0]       cd_data_o,
   output logic                       cd_last_o,
   output logic                       proto_err_o
);
   localparam int unsigned     CntW     = (CdBeats > 1) ? $clog2(CdBeats) : 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(CdBeats - 1);

   typedef enum logic [1:0] {IDLE, SEND, RESP, DATA} state_e;

   state_e                r_state;
   logic [AddrWidth-1:0]  r_addr;
   logic [3:0]            r_snoop;
   logic [2:0]            r_prot;
   logic [NoMst-1:0]      r_ac_pend;
   logic [NoMst-1:0]      r_cr_pend;
   logic [NoMst-1:0]      r_dt_pend;
   logic [4:0]            r_resp;
   logic [SrcW-1:0]       r_sel;
   logic                  r_sel_vld;
   logic [CntW-1:0]       r_cnt;
   logic                  r_proto_err;

   logic                  w_idle, w_send, w_resp_st, w_data_st;
   logic [NoMst-1:0]      w_ac_hs, w_cr_rdy, w_cr_hs, w_dt_hs;
   logic [NoMst-1:0]      w_ac_pend_nxt, w_cr_pend_nxt, w_dt_pend_nxt;
   logic [NoMst-1:0]      w_is_sel, w_drain_done;
   logic [4:0]            w_cr_resp [NoMst];
   logic [DataWidth-1:0]  w_cd_data [NoMst];
   logic                  w_dt_any, w_err_any, w_shr_any, w_wu_any;
   logic                  w_new_sel_vld, w_new_pd, w_pd_nxt;
   logic [SrcW-1:0]       w_new_sel;
   logic                  w_sel_dt, w_cd_last, w_sel_hs, w_sel_done, w_proto_mis;

   assign w_idle    = rst_ni & (r_state == IDLE);
   assign w_send    = rst_ni & (r_state == SEND);
   assign w_resp_st = rst_ni & (r_state == RESP);
   assign w_data_st = rst_ni & (r_state == DATA);

   // A master's CR is only accepted once its own AC has been handed over.
   assign w_ac_hs       = w_send ? (r_ac_pend & snp_ac_ready_i) : '0;
   assign w_cr_rdy      = w_send ? (r_cr_pend & ~r_ac_pend) : '0;
   assign w_cr_hs       = w_cr_rdy & snp_cr_valid_i;
   assign w_ac_pend_nxt = r_ac_pend & ~w_ac_hs;
   assign w_cr_pend_nxt = r_cr_pend & ~w_cr_hs;

   genvar gi;
   generate
      for (gi = 0; gi < NoMst; gi++) begin : g_mst
         assign w_cr_resp[gi]      = snp_cr_resp_i[gi*5 +: 5];
         assign w_cd_data[gi]      = snp_cd_data_i[gi*DataWidth +: DataWidth];
         assign w_dt_hs[gi]        = w_cr_hs[gi] & w_cr_resp[gi][0];
         assign w_is_sel[gi]       = (r_sel == SrcW'(gi));
         assign snp_cd_ready_o[gi] = w_data_st & r_dt_pend[gi] & (w_is_sel[gi] ? cd_ready_i : 1'b1);
         assign w_drain_done[gi]   = w_data_st & r_dt_pend[gi] & ~w_is_sel[gi]
                                   & snp_cd_valid_i[gi] & snp_cd_last_i[gi];
      end
   endgenerate

   // Descending scan so the lowest-index data master wins a same-cycle tie.
   always_comb begin
      w_dt_any      = 1'b0;
      w_err_any     = 1'b0;
      w_shr_any     = 1'b0;
      w_wu_any      = 1'b0;
      w_new_sel_vld = 1'b0;
      w_new_sel     = '0;
      w_new_pd      = 1'b0;
      for (int i = int'(NoMst) - 1; i >= 0; i--) begin
         if (w_cr_hs[i]) begin
            w_dt_any  = w_dt_any  | w_cr_resp[i][0];
            w_err_any = w_err_any | w_cr_resp[i][1];
            w_shr_any = w_shr_any | w_cr_resp[i][3];
            w_wu_any  = w_wu_any  | w_cr_resp[i][4];
            if (w_cr_resp[i][0]) begin
               w_new_sel_vld = 1'b1;
               w_new_sel     = SrcW'(i);
               w_new_pd      = w_cr_resp[i][2];
            end
         end
      end
   end

   assign w_pd_nxt = (!r_sel_vld && w_new_sel_vld) ? w_new_pd : r_resp[2];

   assign w_sel_dt      = r_dt_pend[r_sel];
   assign w_cd_last     = (r_cnt == LastBeat);
   assign w_sel_hs      = cd_valid_o & cd_ready_i;
   assign w_sel_done    = w_sel_hs & w_cd_last;
   assign w_proto_mis   = w_sel_hs & (snp_cd_last_i[r_sel] != w_cd_last);
   assign w_dt_pend_nxt = r_dt_pend & ~w_drain_done & ~({NoMst{w_sel_done}} & w_is_sel);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_snoop     <= '0;
         r_prot      <= '0;
         r_ac_pend   <= '0;
         r_cr_pend   <= '0;
         r_dt_pend   <= '0;
         r_resp      <= '0;
         r_sel       <= '0;
         r_sel_vld   <= 1'b0;
         r_cnt       <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_proto_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (ac_valid_i) begin
                  r_addr    <= ac_addr_i;
                  r_snoop   <= ac_snoop_i;
                  r_prot    <= ac_prot_i;
                  r_ac_pend <= mask_i;
                  r_cr_pend <= mask_i;
                  r_dt_pend <= '0;
                  r_resp    <= '0;
                  r_sel     <= '0;
                  r_sel_vld <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= (mask_i == '0) ? RESP : SEND;
               end
            end
            SEND: begin
               r_ac_pend <= w_ac_pend_nxt;
               r_cr_pend <= w_cr_pend_nxt;
               r_dt_pend <= r_dt_pend | w_dt_hs;
               r_resp    <= {r_resp[4] | w_wu_any, r_resp[3] | w_shr_any, w_pd_nxt,
                             r_resp[1] | w_err_any, r_resp[0] | w_dt_any};
               if (!r_sel_vld && w_new_sel_vld) begin
                  r_sel     <= w_new_sel;
                  r_sel_vld <= 1'b1;
               end
               if (w_ac_pend_nxt == '0 && w_cr_pend_nxt == '0) r_state <= RESP;
            end
            RESP: begin
               if (cr_ready_i) r_state <= (r_dt_pend != '0) ? DATA : IDLE;
            end
            DATA: begin
               r_dt_pend   <= w_dt_pend_nxt;
               r_proto_err <= w_proto_mis;
               if (w_sel_hs) r_cnt <= w_cd_last ? '0 : r_cnt + 1'b1;
               if (w_dt_pend_nxt == '0) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ac_ready_o     = w_idle;
   assign snp_ac_valid_o = w_send ? r_ac_pend : '0;
   assign snp_ac_addr_o  = r_addr;
   assign snp_ac_snoop_o = r_snoop;
   assign snp_ac_prot_o  = r_prot;
   assign snp_cr_ready_o = w_cr_rdy;
   assign cr_valid_o     = w_resp_st;
   assign cr_resp_o      = w_resp_st ? r_resp : '0;
   assign cr_src_o       = w_resp_st ? r_sel : '0;
   assign cd_valid_o     = w_data_st & w_sel_dt & snp_cd_valid_i[r_sel];
   assign cd_data_o      = w_data_st ? w_cd_data[r_sel] : '0;
   assign cd_last_o      = w_data_st & w_sel_dt & w_cd_last;
   assign proto_err_o    = r_proto_err;

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Directed bench for ace_snoop_collector: expected CR/CD results are queued when stimulus
// is driven and popped when the collector presents them.
module tb_ace_snoop_collector;
   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CB = 4;
   localparam int SW = 2;

   typedef struct packed {logic [4:0] resp; logic [SW-1:0] src;} cr_t;
   typedef struct packed {logic [DW-1:0] data; logic last;} cd_t;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              ac_valid_i, ac_ready_o;
   logic [AW-1:0]     ac_addr_i;
   logic [3:0]        ac_snoop_i;
   logic [2:0]        ac_prot_i;
   logic [NM-1:0]     mask_i;
   logic [NM-1:0]     snp_ac_valid_o, snp_ac_ready_i;
   logic [AW-1:0]     snp_ac_addr_o;
   logic [3:0]        snp_ac_snoop_o;
   logic [2:0]        snp_ac_prot_o;
   logic [NM-1:0]     snp_cr_valid_i, snp_cr_ready_o;
   logic [5*NM-1:0]   snp_cr_resp_i;
   logic [NM-1:0]     snp_cd_valid_i, snp_cd_ready_o, snp_cd_last_i;
   logic [DW*NM-1:0]  snp_cd_data_i;
   logic              cr_valid_o, cr_ready_i;
   logic [4:0]        cr_resp_o;
   logic [SW-1:0]     cr_src_o;
   logic              cd_valid_o, cd_ready_i, cd_last_o, proto_err_o;
   logic [DW-1:0]     cd_data_o;

   int  checks = 0;
   int  errors = 0;
   cr_t exp_cr[$];
   cd_t exp_cd[$];

   always #5 clk_i = ~clk_i;

   ace_snoop_collector #(.NoMst(NM), .AddrWidth(AW), .DataWidth(DW), .CdBeats(CB)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
      .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .mask_i(mask_i),
      .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i),
      .snp_ac_addr_o(snp_ac_addr_o), .snp_ac_snoop_o(snp_ac_snoop_o), .snp_ac_prot_o(snp_ac_prot_o),
      .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o), .snp_cr_resp_i(snp_cr_resp_i),
      .snp_cd_valid_i(snp_cd_valid_i), .snp_cd_ready_o(snp_cd_ready_o),
      .snp_cd_data_i(snp_cd_data_i), .snp_cd_last_i(snp_cd_last_i),
      .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o), .cr_src_o(cr_src_o),
      .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
      .cd_last_o(cd_last_o), .proto_err_o(proto_err_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat_data(input int i, input int b);
      return 32'hD000_0000 + 32'(i * 256 + b);
   endfunction

   task automatic issue(input logic [NM-1:0] m, input logic [AW-1:0] a, input logic [3:0] s,
                        input logic [4:0] er, input logic [SW-1:0] es);
      int n = 0;
      while (!ac_ready_o && n < 20) begin tick(); n++; end
      chk("ac_ready_idle", 64'(ac_ready_o), 1);
      ac_valid_i = 1'b1; mask_i = m; ac_addr_i = a; ac_snoop_i = s; ac_prot_i = 3'b010;
      exp_cr.push_back('{er, es});
      tick();
      ac_valid_i = 1'b0; mask_i = '0;
      chk("ac_addr_latched", 64'(snp_ac_addr_o), 64'(a));
      chk("ac_snoop_latched", 64'(snp_ac_snoop_o), 64'(s));
      $display("issue mask=%b addr=%h snoop=%h", m, a, s);
   endtask

   task automatic wait_resp(input int hold);
      int  n = 0;
      cr_t e;
      while (!cr_valid_o && n < 20) begin tick(); n++; end
      chk("cr_valid", 64'(cr_valid_o), 1);
      chk("cr_queue_nonempty", 64'(exp_cr.size() != 0), 1);
      e = (exp_cr.size() != 0) ? exp_cr.pop_front() : '0;
      chk("cr_resp", 64'(cr_resp_o), 64'(e.resp));
      chk("cr_src", 64'(cr_src_o), 64'(e.src));
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("cr_hold_valid", 64'(cr_valid_o), 1);
         chk("cr_hold_resp", 64'(cr_resp_o), 64'(e.resp));
      end
      cr_ready_i = 1'b1;
      tick();
      cr_ready_i = 1'b0;
      settle();
      $display("cr resp=%b src=%0d", e.resp, e.src);
   endtask

   task automatic run_data(input int sel, input logic [NM-1:0] dmask, input int stall, input int early);
      int            beat[NM];
      int            cyc = 0;
      int            pulses = 0;
      bit            done = 1'b0;
      logic [NM-1:0] act;
      cd_t           e;
      act = dmask;
      act[sel] = 1'b1;
      for (int i = 0; i < NM; i++) beat[i] = act[i] ? 0 : CB;
      for (int b = 0; b < CB; b++) exp_cd.push_back('{beat_data(sel, b), b == CB - 1});
      while (!done && cyc < 60) begin
         cd_ready_i = (cyc >= stall);
         for (int i = 0; i < NM; i++) begin
            snp_cd_valid_i[i] = (beat[i] < CB);
            snp_cd_data_i[i*DW +: DW] = beat_data(i, beat[i]);
            snp_cd_last_i[i] = (beat[i] == CB - 1) || (i == sel && beat[i] == early);
         end
         settle();
         if (cyc < stall) begin
            chk("stall_sel_ready", 64'(snp_cd_ready_o[sel]), 0);
            chk("stall_data", 64'(cd_data_o), 64'(beat_data(sel, beat[sel])));
         end
         for (int i = 0; i < NM; i++)
            if (i != sel && beat[i] < CB) chk("drain_ready", 64'(snp_cd_ready_o[i]), 1);
         if (cd_valid_o && cd_ready_i) begin
            chk("cd_queue_nonempty", 64'(exp_cd.size() != 0), 1);
            e = (exp_cd.size() != 0) ? exp_cd.pop_front() : '0;
            chk("cd_data", 64'(cd_data_o), 64'(e.data));
            chk("cd_last", 64'(cd_last_o), 64'(e.last));
            $display("cd beat data=%h last=%b", cd_data_o, cd_last_o);
         end
         for (int i = 0; i < NM; i++)
            if (snp_cd_valid_i[i] && snp_cd_ready_o[i]) beat[i]++;
         tick();
         cyc++;
         if (proto_err_o) pulses++;
         done = 1'b1;
         for (int i = 0; i < NM; i++) if (beat[i] < CB) done = 1'b0;
      end
      snp_cd_valid_i = '0; snp_cd_last_i = '0; cd_ready_i = 1'b0;
      settle();
      chk("data_done", 64'(done), 1);
      chk("proto_err_pulses", 64'(pulses), (early >= 0) ? 64'd1 : 64'd0);
      chk("idle_after_data", 64'(ac_ready_o), 1);
      chk("cd_queue_empty", 64'(exp_cd.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
      mask_i = '0; snp_ac_ready_i = '0; snp_cr_valid_i = '0; snp_cr_resp_i = '0;
      snp_cd_valid_i = '0; snp_cd_data_i = '0; snp_cd_last_i = '0; cr_ready_i = 1'b0; cd_ready_i = 1'b0;
      tick(); tick();
      chk("rst_ac_ready", 64'(ac_ready_o), 0);
      chk("rst_cr_valid", 64'(cr_valid_o), 0);
      chk("rst_snp_ac_valid", 64'(snp_ac_valid_o), 0);
      chk("rst_proto_err", 64'(proto_err_o), 0);
      rst_ni = 1'b1;
      settle();
      chk("idle_ac_ready", 64'(ac_ready_o), 1);

      // All four masters, no data, staggered AC acceptance
      snp_cr_valid_i = 4'hF;
      issue(4'hF, 32'h1000_0040, 4'h7, 5'b00000, 0);
      chk("t1_ac_valid", 64'(snp_ac_valid_o), 64'hF);
      chk("t1_cr_ready0", 64'(snp_cr_ready_o), 0);
      snp_ac_ready_i = 4'b0001; tick();
      chk("t1_ac_valid1", 64'(snp_ac_valid_o), 64'b1110);
      snp_ac_ready_i = 4'b0110; tick();
      chk("t1_cr_ready2", 64'(snp_cr_ready_o), 64'b0110);
      snp_ac_ready_i = 4'b1000; tick();
      chk("t1_cr_ready3", 64'(snp_cr_ready_o), 64'b1000);
      chk("t1_no_resp_yet", 64'(cr_valid_o), 0);
      snp_ac_ready_i = '0;
      tick();
      wait_resp(0);
      snp_cr_valid_i = '0;
      chk("t1_ac_ready_back", 64'(ac_ready_o), 1);
      chk("t1_no_cd", 64'(cd_valid_o), 0);

      // Master2 DT|PassDirty first, master1 DT|IsShared later
      snp_ac_ready_i = 4'hF;
      issue(4'b0110, 32'h2000_0080, 4'h1, 5'b01101, 2);
      tick();
      chk("t2_cr_ready", 64'(snp_cr_ready_o), 64'b0110);
      tick(); tick();
      snp_cr_valid_i[2] = 1'b1; snp_cr_resp_i[2*5 +: 5] = 5'b00101;
      tick();
      snp_cr_valid_i[2] = 1'b0;
      settle();
      chk("t2_still_send", 64'(cr_valid_o), 0);
      tick();
      snp_cr_valid_i[1] = 1'b1; snp_cr_resp_i[1*5 +: 5] = 5'b01001;
      tick();
      snp_cr_valid_i[1] = 1'b0;
      wait_resp(2);
      run_data(2, 4'b0010, 0, -1);

      // Masters 0 and 3 return DT in the same cycle; output stalled for 5 cycles
      snp_cr_resp_i[0*5 +: 5] = 5'b00001;
      snp_cr_resp_i[3*5 +: 5] = 5'b00101;
      snp_cr_valid_i = 4'b1001;
      issue(4'b1001, 32'h3000_00C0, 4'h2, 5'b00001, 0);
      wait_resp(0);
      snp_cr_valid_i = '0;
      run_data(0, 4'b1000, 5, -1);

      // Early last from the selected master, Error merged
      snp_cr_resp_i[0*5 +: 5] = 5'b00011;
      snp_cr_valid_i = 4'b0001;
      issue(4'b0001, 32'h4000_0100, 4'h3, 5'b00011, 0);
      wait_resp(0);
      snp_cr_valid_i = '0;
      run_data(0, 4'b0000, 0, 1);

      // Empty mask goes straight to the response
      issue(4'b0000, 32'h5000_0140, 4'h4, 5'b00000, 0);
      chk("t6_resp_next_cycle", 64'(cr_valid_o), 1);
      wait_resp(0);
      chk("t6_idle", 64'(ac_ready_o), 1);

      // Reset in the middle of a data phase
      snp_cr_resp_i[0*5 +: 5] = 5'b00001;
      snp_cr_valid_i = 4'b0001;
      issue(4'b0001, 32'h6000_0180, 4'h5, 5'b00001, 0);
      wait_resp(0);
      snp_cr_valid_i = '0;
      snp_cd_valid_i[0] = 1'b1; snp_cd_data_i[0 +: DW] = beat_data(0, 0); cd_ready_i = 1'b1;
      settle();
      chk("t7_in_data", 64'(cd_valid_o), 1);
      rst_ni = 1'b0;
      tick();
      chk("t7_rst_ac_valid", 64'(snp_ac_valid_o), 0);
      chk("t7_rst_cr_ready", 64'(snp_cr_ready_o), 0);
      chk("t7_rst_cd_ready", 64'(snp_cd_ready_o), 0);
      chk("t7_rst_cr_valid", 64'(cr_valid_o), 0);
      chk("t7_rst_cd_valid", 64'(cd_valid_o), 0);
      chk("t7_rst_ac_ready", 64'(ac_ready_o), 0);
      rst_ni = 1'b1;
      settle();
      chk("t7_idle_after_rst", 64'(ac_ready_o), 1);
      chk("t7_no_cd_after_rst", 64'(cd_valid_o), 0);
      snp_cd_valid_i = '0; cd_ready_i = 1'b0;
      exp_cd.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ace_snoop_collector.md
Name: ace_snoop_collector

Overview:
- Sits between the CCU snoop FSM and the per-master snoop ports of one master group.
- Takes one snoop request and broadcasts it on AC to every master selected by a mask.
- Collects each master's CR response and merges them into a single response.
- Forwards the cacheline CD data of one chosen master and drains CD data from every other master that offered data.

Parameters:
NoMst, 4, number of snooped masters in the group (>=1)
AddrWidth, 64, AC address width
DataWidth, 64, CD data width
CdBeats, 4, CD beats per cacheline (CachelineBits / DataWidth, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
ac_valid_i  in  1  snoop request valid from CCU FSM
ac_ready_o  out  1  request accepted
ac_addr_i  in  AddrWidth  snoop address
ac_snoop_i  in  4  AC snoop type
ac_prot_i  in  3  AC prot
mask_i  in  NoMst  masters to snoop, sampled with request
snp_ac_valid_o  out  NoMst  per-master AC valid
snp_ac_ready_i  in  NoMst  per-master AC ready
snp_ac_addr_o  out  AddrWidth  latched address, shared by all masters
snp_ac_snoop_o  out  4  latched snoop type, shared
snp_ac_prot_o  out  3  latched prot, shared
snp_cr_valid_i  in  NoMst  per-master CR valid
snp_cr_ready_o  out  NoMst  per-master CR ready
snp_cr_resp_i  in  5*NoMst  per-master CR resp, bits [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique
snp_cd_valid_i  in  NoMst  per-master CD valid
snp_cd_ready_o  out  NoMst  per-master CD ready
snp_cd_data_i  in  DataWidth*NoMst  per-master CD data
snp_cd_last_i  in  NoMst  per-master CD last
cr_valid_o  out  1  merged response valid
cr_ready_i  in  1  merged response ready
cr_resp_o  out  5  merged CR resp
cr_src_o  out  max(1,$clog2(NoMst))  index of selected data master
cd_valid_o  out  1  forwarded data valid
cd_ready_i  in  1  forwarded data ready
cd_data_o  out  DataWidth  forwarded data
cd_last_o  out  1  last beat, derived from the beat counter
proto_err_o  out  1  one-cycle pulse on a CD last/count mismatch

Behaviour:
- One clock. Synchronous active-low reset.
- While rst_ni=0: state=IDLE, all pending masks cleared, merged resp and counter cleared, every valid/ready output 0, ac_ready_o=0.
- Reset mid-operation returns to IDLE at the next edge. In-flight snoop transactions are abandoned.

- IDLE:
  - ac_ready_o=1.
  - On handshake, latch addr/snoop/prot, ac_pend=mask_i, cr_pend=mask_i, merged resp=0.
  - Go to SEND. If mask_i==0, go directly to RESP with resp=0 and cr_src_o=0.
- SEND:
  - snp_ac_valid_o=ac_pend. Clear bit i on snp_ac_valid_o[i]&snp_ac_ready_i[i].
  - snp_cr_ready_o[i]=cr_pend[i]&~ac_pend[i]. CR is accepted only after that master's AC handshake.
  - On each CR handshake, clear cr_pend[i] and merge:
    - DataTransfer, Error, IsShared, WasUnique are ORed.
    - The first accepted master with DataTransfer=1 becomes sel (lowest index on a same-cycle tie).
    - PassDirty is taken from sel only.
    - dt_pend[i] is set when DataTransfer=1.
  - Go to RESP when ac_pend==0 and cr_pend==0; this includes CRs accepted in that same cycle.
- RESP:
  - cr_valid_o=1, holding cr_resp_o and cr_src_o stable until cr_ready_i.
  - After the handshake: go to DATA if dt_pend!=0, else IDLE.
  - ac_ready_o=0 until back in IDLE.
- DATA:
  - Selected master: cd_valid_o=snp_cd_valid_i[sel], cd_data_o=snp_cd_data_i[sel], snp_cd_ready_o[sel]=cd_ready_i. This is a combinational pass-through with zero latency.
  - Every other i with dt_pend[i]=1: snp_cd_ready_o[i]=1 (drain); data is discarded.
  - Beat counter counts sel handshakes, 0..CdBeats-1. cd_last_o=(cnt==CdBeats-1).
  - When snp_cd_last_i[sel] disagrees with cd_last_o on a handshake, pulse proto_err_o. Completion still follows the counter.
  - Drained masters complete on their own snp_cd_last_i.
  - Clear dt_pend[i] on completion. When dt_pend==0, go to IDLE with cnt=0.
- Error=1 does not alter the flow; a master with DataTransfer=1 still sends data.
- Outputs not listed for a state are 0 in that state.
- CdBeats=1: every sel beat is last.

Test Plan:
- mask=4'b1111, all CR resp=0, AC readies staggered over 3 cycles → one cr_valid_o with resp=0 and no CD phase; ac_ready_o is back to 1 one cycle after the cr handshake.
- mask=4'b0110; master2 CR=DT|PassDirty at cycle 5, master1 CR=DT|IsShared at cycle 7 → cr_src_o=2, cr_resp_o=5'b01101. Master2's 4 beats are forwarded with cd_last_o on beat 3; master1's 4 beats are drained; return to IDLE.
- Masters 0 and 3 both return DT in the same cycle → cr_src_o=0.
- cd_ready_i held low for 5 cycles in DATA → snp_cd_ready_o[sel]=0; data is stable and no beat is lost.
- Selected master asserts snp_cd_last_i on beat 1 with CdBeats=4 → proto_err_o pulses once; the transfer still ends after beat 3.
- mask=0 → RESP on the next cycle with resp=0. Separately, rst_ni low during DATA → next cycle all valids and readies are 0 and state is IDLE.
